// File: rtl/wb_slave_mux_if.sv
// Bus bundle for wb_slave_mux: upstream pipelined-Wishbone master signals,
// the shared/per-slave fan-out towards the slaves and the error statistics.
// The "slave" modport is the mux's own view; "master" is the environment view.
interface wb_slave_mux_if #(
  parameter int SLAVES = 2
);
  logic [31:0]          m_addr_i;
  logic [31:0]          m_data_i;
  logic [3:0]           m_sel_i;
  logic                 m_we_i;
  logic                 m_stb_i;
  logic                 m_cyc_i;
  logic [31:0]          m_data_o;
  logic                 m_ack_o;
  logic                 m_err_o;
  logic                 m_stall_o;
  logic [31:0]          s_addr_o;
  logic [31:0]          s_data_o;
  logic [3:0]           s_sel_o;
  logic                 s_we_o;
  logic [SLAVES-1:0]    s_stb_o;
  logic [SLAVES*32-1:0] s_data_i;
  logic [SLAVES-1:0]    s_ack_i;
  logic [SLAVES-1:0]    s_stall_i;
  logic [15:0]          err_count_o;

  modport slave (
    input  m_addr_i, m_data_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
    output m_data_o, m_ack_o, m_err_o, m_stall_o,
    output s_addr_o, s_data_o, s_sel_o, s_we_o, s_stb_o,
    input  s_data_i, s_ack_i, s_stall_i,
    output err_count_o
  );

  modport master (
    output m_addr_i, m_data_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
    input  m_data_o, m_ack_o, m_err_o, m_stall_o,
    input  s_addr_o, s_data_o, s_sel_o, s_we_o, s_stb_o,
    output s_data_i, s_ack_i, s_stall_i,
    input  err_count_o
  );
endinterface

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: N-way pipelined-Wishbone slave selector.
// Decodes m_addr_i[SEL_HI:SEL_LO] to a slave, keeps an ordered tracker of
// in-flight requests (all to one slave at a time), routes the head slave's
// ack/data back with zero latency and answers unmapped or hung requests with err.
// Optional macro WB_MUX_STATS_EN enables the saturating error counter on
// err_count_o; without it err_count_o is tied to zero.
module wb_slave_mux #(
  parameter int SLAVES      = 2,
  parameter int SEL_HI      = 31,
  parameter int SEL_LO      = 31,
  parameter int OUTSTANDING = 4,
  parameter int TIMEOUT     = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_slave_mux_if.slave bus
);
  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [SEL_W-1:0]  w_idx;
  logic              w_mapped;
  logic              w_empty;
  logic              w_full;
  logic              w_block;
  logic              w_reqStall;
  logic              w_stall;
  logic              w_accept;
  logic [SLAVES-1:0] w_stb;
  logic              w_headMapped;
  logic [SEL_W-1:0]  w_headIdx;
  logic              w_headValid;
  logic              w_headAck;
  logic [31:0]       w_headData;
  logic              w_ack;
  logic              w_err;
  logic              w_pop;

  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [SEL_W-1:0]  r_lastIdx;
  logic [15:0]       r_timer;
  logic              r_trkMapped [OUTSTANDING];
  logic [SEL_W-1:0]  r_trkIdx    [OUTSTANDING];

  assign w_idx        = bus.m_addr_i[SEL_HI:SEL_LO];
  assign w_mapped     = (32'(w_idx) < 32'(SLAVES));
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(OUTSTANDING));
  assign w_headMapped = r_trkMapped[r_rdPtr];
  assign w_headIdx    = r_trkIdx[r_rdPtr];

  // A new request must wait when the tracker is full, when it targets a
  // different slave than the ones still in flight, or when the cycle is dropped.
  assign w_block  = w_full | (~w_empty & (w_idx != r_lastIdx)) | ~bus.m_cyc_i;
  assign w_stall  = bus.m_stb_i & (w_block | (w_mapped & w_reqStall));
  assign w_accept = bus.m_stb_i & ~w_stall;

  // Select the addressed slave's stall and the head slave's ack/data, and build the strobe vector.
  always_comb begin
    w_reqStall = 1'b0;
    w_headAck  = 1'b0;
    w_headData = '0;
    w_stb      = '0;
    for (int k = 0; k < SLAVES; k++) begin
      if (w_idx == SEL_W'(k)) begin
        w_reqStall = bus.s_stall_i[k];
        w_stb[k]   = bus.m_stb_i & w_mapped & ~w_block;
      end
      if (w_headIdx == SEL_W'(k)) begin
        w_headAck  = bus.s_ack_i[k];
        w_headData = bus.s_data_i[32*k +: 32];
      end
    end
  end

  // Responses only exist for a live head entry; a dropped cycle or a reset silences them.
  // The timer counts completed waiting cycles of the head, so a mapped head gets
  // TIMEOUT cycles to ack and an unmapped head errors on its second head cycle.
  assign w_headValid = ~w_empty & bus.m_cyc_i & ~rst_i;
  assign w_ack       = w_headValid & w_headMapped & w_headAck;
  assign w_err       = w_headValid &
                       ((w_headMapped & ~w_headAck & (r_timer == 16'(TIMEOUT - 1))) |
                        (~w_headMapped & (r_timer != 16'd0)));
  assign w_pop       = w_ack | w_err;

  assign bus.m_ack_o   = w_ack;
  assign bus.m_err_o   = w_err;
  assign bus.m_stall_o = w_stall;
  assign bus.m_data_o  = (~w_empty & w_headMapped) ? w_headData : 32'h0;
  assign bus.s_addr_o  = bus.m_addr_i;
  assign bus.s_data_o  = bus.m_data_i;
  assign bus.s_sel_o   = bus.m_sel_i;
  assign bus.s_we_o    = bus.m_we_i;
  assign bus.s_stb_o   = w_stb;

  // Record the target of every accepted request at the tail of the tracker.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_trkMapped[r_wrPtr] <= w_mapped;
      r_trkIdx[r_wrPtr]    <= w_idx;
    end
  end

  // Tracker occupancy, pointers, last target and head wait timer; a dropped cycle flushes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_lastIdx <= '0;
      r_timer   <= '0;
    end else if (~bus.m_cyc_i) begin
      r_count <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_timer <= '0;
    end else begin
      if (w_accept) begin
        r_wrPtr   <= r_wrPtr + 1'b1;
        r_lastIdx <= w_idx;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop | w_empty) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

`ifdef WB_MUX_STATS_EN
  logic [15:0] r_errCount;

  // Count error responses, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_errCount <= '0;
    end else if (w_err && (r_errCount != 16'hFFFF)) begin
      r_errCount <= r_errCount + 1'b1;
    end
  end

  assign bus.err_count_o = r_errCount;
`else
  assign bus.err_count_o = 16'h0000;
`endif
endmodule
